stm_reg_reader: RTL and testbench
=================================

// Module: stm_reg_reader
// PURPOSE
//  Read-side sequencer for the ARM register file: executes the register-file half of an STM
//  (store multiple). Walks a 16-bit register list lowest-to-highest, drives the RegFile read port
//  (Ra -> Y0), and streams {address, data} words to the memory interface over valid/ready.
//  Also returns the base writeback address. Sits between the control unit and the data-memory port.
// PARAMETERS
//  DATA_W   32  register/memory data width
//  ADDR_W   32  memory address width
//  STEP     4   byte increment per transferred word
// PORTS
//  clk        in   1       system clock, all state updates on rising edge
//  clr        in   1       synchronous reset, active-high
//  start      in   1       start request; sampled only in IDLE
//  reg_list   in   16      bit i set = store Ri; sampled with start
//  base_addr  in   ADDR_W  base register value; sampled with start
//  mode       in   2       00=IA 01=IB 10=DA 11=DB; sampled with start
//  rf_ra      out  4       RegFile read address (to Ra)
//  rf_y0      in   DATA_W  RegFile read data (from Y0), combinational w.r.t. rf_ra
//  mem_valid  out  1       {mem_addr, mem_data} valid
//  mem_ready  in   1       memory accepts word when valid & ready at a rising edge
//  mem_addr   out  ADDR_W  word address of current transfer
//  mem_data   out  DATA_W  store data of current transfer
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse at end of operation
//  wb_addr    out  ADDR_W  base writeback value; valid while done=1, held until next start
// BEHAVIOUR
//  Reset (clr=1 at edge): state=IDLE; rf_ra=0, mem_valid=0, mem_addr=0, mem_data=0, busy=0,
//   done=0, wb_addr=0; remaining list cleared. clr mid-operation aborts; no further transfers.
//  n = popcount(reg_list). Start address (lowest reg always at lowest address):
//   IA: base; IB: base+STEP; DA: base-STEP*n+STEP; DB: base-STEP*n.
//   wb_addr: IA/IB base+STEP*n; DA/DB base-STEP*n. All arithmetic mod 2^ADDR_W (wrap allowed).
//  States: IDLE, READ, SEND, FIN.
//   IDLE: start=1 -> latch list/mode, compute start addr and wb_addr; list!=0 -> READ, list==0 -> FIN.
//   READ (1 cycle): rf_ra = index of lowest set bit of remaining list; at edge mem_data<=rf_y0,
//    mem_valid<=1 -> SEND. mem_addr already holds current address.
//   SEND: hold mem_valid/mem_addr/mem_data stable while mem_ready=0. On valid&ready edge:
//    clear that bit, mem_addr+=STEP, mem_valid<=0; remaining!=0 -> READ, else -> FIN.
//   FIN (1 cycle): done=1, busy=1 -> IDLE. done deasserts next cycle.
//  rf_ra = lowest set index of remaining list in READ/SEND, 0 in IDLE/FIN.
//  Throughput: 2 cycles per register with mem_ready=1; total = 2n+1 cycles start-to-done(FIN).
//  start while busy: ignored, latched operands unchanged. Empty list: no mem_valid, done after 1 cycle.
//  mem_valid never asserted outside SEND; never drops without handshake except via clr.
// TESTING
//  1 IA: list=16'h0206 (R1,R2,R9 preloaded 0x11,0x22,0x99), base=0x100, ready=1 -> words
//    (0x100,0x11),(0x104,0x22),(0x108,0x99); rf_ra 1,2,9; done at cycle 7; wb_addr=0x10C.
//  2 DB: same list, base=0x100 -> addrs 0xF4,0xF8,0xFC in R1,R2,R9 order; wb_addr=0xF4.
//    IB -> 0x104..0x10C/wb 0x10C; DA -> 0xF8..0x100/wb 0xF4.
//  3 Backpressure: mem_ready=0 for 3 cycles on 2nd word -> valid/addr/data held constant, no skip/dup.
//  4 list=16'hFFFF, IA, base=0xFFFFFFF8 -> 16 words R0..R15, addr wraps 0xFFFFFFF8,0xFFFFFFFC,0x0,...;
//    wb_addr=0x38. list=0 -> no mem_valid, done 1 cycle after start, wb_addr=base.
//  5 start pulsed during SEND with different list -> ignored; original sequence completes unchanged.
//  6 clr asserted during SEND of word 2 -> next cycle all outputs 0, IDLE; fresh start runs test 1 cleanly.

Source files
------------

// File: rtl/stm_reg_reader.sv
// stm_reg_reader: read-side sequencer for an STM (store multiple).
// Walks a 16-bit register list from the lowest register to the highest. For each register it
// drives the register-file read port and streams one {address, data} word to memory over
// valid/ready. It also returns the base writeback address.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   clr        synchronous reset, active-high; also aborts an operation in flight
//   start      start request, sampled only in IDLE
//   reg_list   bit i set = store Ri (sampled with start)
//   base_addr  base register value (sampled with start)
//   mode       00=IA 01=IB 10=DA 11=DB (sampled with start)
//   rf_ra      register-file read address
//   rf_y0      register-file read data, combinational with respect to rf_ra
//   mem_valid  {mem_addr, mem_data} valid
//   mem_ready  memory accepts the word when valid & ready at a rising edge
//   mem_addr   word address of the current transfer
//   mem_data   store data of the current transfer
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of an operation
//   wb_addr    base writeback value; held until the next start
module stm_reg_reader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        mode,
  output logic [3:0]        rf_ra,
  input  logic [DATA_W-1:0] rf_y0,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wb_addr
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StFin} state_e;

  state_e            state_q, state_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

  logic [ADDR_W-1:0] step_w;
  logic [ADDR_W-1:0] step_n;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Scans from the top so that the final assignment is the lowest set bit.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign step_w = ADDR_W'(STEP);
  assign step_n = step_w * ADDR_W'(popcount16(reg_list));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_valid_d = mem_valid_q;
    wb_addr_d   = wb_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = reg_list;
          // The lowest register always goes to the lowest address, so the decrementing modes
          // start at the bottom of the block and count upward as well.
          unique case (mode)
            2'b00: begin
              mem_addr_d = base_addr;
              wb_addr_d  = base_addr + step_n;
            end
            2'b01: begin
              mem_addr_d = base_addr + step_w;
              wb_addr_d  = base_addr + step_n;
            end
            2'b10: begin
              mem_addr_d = base_addr - step_n + step_w;
              wb_addr_d  = base_addr - step_n;
            end
            default: begin
              mem_addr_d = base_addr - step_n;
              wb_addr_d  = base_addr - step_n;
            end
          endcase
          state_d = (reg_list != 16'd0) ? StRead : StFin;
        end
      end
      StRead: begin
        mem_data_d  = rf_y0;
        mem_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (mem_ready) begin
          remaining_d = remaining_q & (remaining_q - 16'd1);
          mem_addr_d  = mem_addr_q + step_w;
          mem_valid_d = 1'b0;
          state_d     = (remaining_d != 16'd0) ? StRead : StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_valid_q <= 1'b0;
      wb_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_valid_q <= mem_valid_d;
      wb_addr_q   <= wb_addr_d;
    end
  end

  assign rf_ra     = (state_q == StRead || state_q == StSend) ? lowest_idx(remaining_q) : 4'd0;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign wb_addr   = wb_addr_q;

endmodule

// File: tb/tb_stm_reg_reader.sv
// Directed testbench for stm_reg_reader: one task per scenario, inline comparisons.
module tb_stm_reg_reader;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] reg_list;
  logic [31:0] base_addr;
  logic [1:0]  mode;
  logic [3:0]  rf_ra;
  logic [31:0] rf_y0;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic [31:0] wb_addr;

  logic [31:0] rf [16];
  assign rf_y0 = rf[rf_ra];

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];
  logic [3:0]  cap_ra   [$];

  stm_reg_reader #(
    .DATA_W(32),
    .ADDR_W(32),
    .STEP  (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .reg_list (reg_list),
    .base_addr(base_addr),
    .mode     (mode),
    .rf_ra    (rf_ra),
    .rf_y0    (rf_y0),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .busy     (busy),
    .done     (done),
    .wb_addr  (wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word; the handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (mem_valid && mem_ready) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_data);
      cap_ra.push_back(rf_ra);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_ra.delete();
  endtask

  task automatic load_rf_basic();
    for (int i = 0; i < 16; i++) rf[i] = 32'hDEAD_0000 + i;
    rf[1] = 32'h11;
    rf[2] = 32'h22;
    rf[9] = 32'h99;
  endtask

  // Pulses start for one cycle; afterwards cyc counts the cycle the sequencer is in (1 = first).
  task automatic start_op(input logic [15:0] l, input logic [31:0] b, input logic [1:0] m);
    reg_list  = l;
    base_addr = b;
    mode      = m;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  task automatic wait_done(input int limit);
    while (!done && cyc < limit) tick();
  endtask

  task automatic test_reset();
    clr   = 1'b1;
    start = 1'b1;
    reg_list  = 16'h0006;
    base_addr = 32'h100;
    mode      = 2'b00;
    tick();
    tick();
    start = 1'b0;
    compared++;
    if ({mem_valid, busy, done} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags: got valid/busy/done=%b want 000", {mem_valid, busy, done});
    end
    compared++;
    if (mem_addr !== 32'h0 || mem_data !== 32'h0 || wb_addr !== 32'h0 || rf_ra !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_data: got addr=%h data=%h wb=%h ra=%h want all 0",
               mem_addr, mem_data, wb_addr, rf_ra);
    end
    clr = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle_after: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_ia();
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    logic [3:0]  er [3];
    ea = '{32'h100, 32'h104, 32'h108};
    ed = '{32'h11, 32'h22, 32'h99};
    er = '{4'd1, 4'd2, 4'd9};
    load_rf_basic();
    clear_cap();
    mem_ready = 1'b1;
    start_op(16'h0206, 32'h100, 2'b00);
    compared++;
    if (busy !== 1'b1 || rf_ra !== 4'd1) begin
      mismatched++;
      $display("FAIL ia_first_read: got busy=%b ra=%0d want 1 and 1", busy, rf_ra);
    end
    wait_done(100);
    compared++;
    if (cyc !== 7) begin
      mismatched++;
      $display("FAIL ia_done_cycle: got %0d want 7", cyc);
    end
    compared++;
    if (wb_addr !== 32'h10C) begin
      mismatched++;
      $display("FAIL ia_wb_addr: got %h want 0000010c", wb_addr);
    end
    compared++;
    if (cap_addr.size() !== 3) begin
      mismatched++;
      $display("FAIL ia_word_count: got %0d want 3", cap_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i] || cap_ra[i] !== er[i]) begin
        mismatched++;
        $display("FAIL ia_word%0d: got addr=%h data=%h ra=%0d want addr=%h data=%h ra=%0d",
                 i, cap_addr[i], cap_data[i], cap_ra[i], ea[i], ed[i], er[i]);
      end
    end
    tick();
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || wb_addr !== 32'h10C) begin
      mismatched++;
      $display("FAIL ia_after_done: got done=%b busy=%b wb=%h want 0 0 0000010c",
               done, busy, wb_addr);
    end
  endtask

  task automatic test_modes();
    logic [1:0]  md [3];
    logic [31:0] a0 [3];
    logic [31:0] wb [3];
    md = '{2'b11, 2'b01, 2'b10};
    a0 = '{32'hF4, 32'h104, 32'hF8};
    wb = '{32'hF4, 32'h10C, 32'hF4};
    load_rf_basic();
    mem_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      clear_cap();
      start_op(16'h0206, 32'h100, md[m]);
      wait_done(100);
      compared++;
      if (wb_addr !== wb[m] || cyc !== 7) begin
        mismatched++;
        $display("FAIL mode%0d_wb: got wb=%h cyc=%0d want wb=%h cyc=7", md[m], wb_addr, cyc, wb[m]);
      end
      compared++;
      if (cap_addr.size() !== 3 || cap_addr[0] !== a0[m] || cap_addr[1] !== a0[m] + 32'd4 ||
          cap_addr[2] !== a0[m] + 32'd8 || cap_data[0] !== 32'h11 || cap_data[1] !== 32'h22 ||
          cap_data[2] !== 32'h99) begin
        mismatched++;
        $display("FAIL mode%0d_words: got n=%0d a=%h,%h,%h d=%h,%h,%h want a0=%h d=11,22,99",
                 md[m], cap_addr.size(), cap_addr[0], cap_addr[1], cap_addr[2],
                 cap_data[0], cap_data[1], cap_data[2], a0[m]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    load_rf_basic();
    clear_cap();
    mem_ready = 1'b1;
    start_op(16'h0206, 32'h100, 2'b00);
    tick();  // cycle 2: word 0 accepted
    tick();  // cycle 3: read R2
    tick();  // cycle 4: word 1 offered
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h104 || mem_data !== 32'h22 || rf_ra !== 4'd2) begin
        mismatched++;
        $display("FAIL bp_hold%0d: got v=%b a=%h d=%h ra=%0d want 1 00000104 00000022 2",
                 k, mem_valid, mem_addr, mem_data, rf_ra);
      end
      if (k < 2) tick();
    end
    tick();  // cycle 7
    mem_ready = 1'b1;
    wait_done(100);
    compared++;
    if (cyc !== 10) begin
      mismatched++;
      $display("FAIL bp_done_cycle: got %0d want 10", cyc);
    end
    compared++;
    if (cap_addr.size() !== 3 || cap_addr[1] !== 32'h104 || cap_data[1] !== 32'h22 ||
        cap_addr[2] !== 32'h108 || cap_data[2] !== 32'h99) begin
      mismatched++;
      $display("FAIL bp_words: got n=%0d w1=%h/%h w2=%h/%h want 3 104/22 108/99",
               cap_addr.size(), cap_addr[1], cap_data[1], cap_addr[2], cap_data[2]);
    end
    tick();
  endtask

  task automatic test_wrap_full();
    int bad;
    logic [31:0] ea;
    for (int i = 0; i < 16; i++) rf[i] = 32'hA000_0000 + i;
    clear_cap();
    mem_ready = 1'b1;
    start_op(16'hFFFF, 32'hFFFF_FFF8, 2'b00);
    wait_done(200);
    compared++;
    if (cyc !== 33 || wb_addr !== 32'h38) begin
      mismatched++;
      $display("FAIL wrap_done: got cyc=%0d wb=%h want 33 00000038", cyc, wb_addr);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      ea = 32'hFFFF_FFF8 + 32'(4 * i);
      if (cap_addr[i] !== ea || cap_data[i] !== 32'hA000_0000 + i || cap_ra[i] !== 4'(i)) bad++;
    end
    compared++;
    if (cap_addr.size() !== 16 || bad != 0) begin
      mismatched++;
      $display("FAIL wrap_words: got n=%0d bad=%0d w2addr=%h want 16 0 00000000",
               cap_addr.size(), bad, cap_addr[2]);
    end
    tick();
  endtask

  task automatic test_empty();
    int saw_valid;
    clear_cap();
    mem_ready = 1'b1;
    saw_valid = 0;
    start_op(16'h0000, 32'h1234, 2'b10);
    compared++;
    if (done !== 1'b1 || busy !== 1'b1 || wb_addr !== 32'h1234) begin
      mismatched++;
      $display("FAIL empty_done: got done=%b busy=%b wb=%h want 1 1 00001234", done, busy, wb_addr);
    end
    for (int k = 0; k < 3; k++) begin
      if (mem_valid) saw_valid++;
      tick();
    end
    compared++;
    if (saw_valid != 0 || cap_addr.size() !== 0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL empty_no_valid: got valid_cycles=%0d words=%0d done=%b want 0 0 0",
               saw_valid, cap_addr.size(), done);
    end
  endtask

  task automatic test_start_ignored();
    load_rf_basic();
    clear_cap();
    mem_ready = 1'b1;
    start_op(16'h0206, 32'h100, 2'b00);
    tick();  // cycle 2: SEND
    reg_list  = 16'h00F0;
    base_addr = 32'h500;
    mode      = 2'b11;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    compared++;
    if (cyc !== 7 || wb_addr !== 32'h10C) begin
      mismatched++;
      $display("FAIL ignore_done: got cyc=%0d wb=%h want 7 0000010c", cyc, wb_addr);
    end
    compared++;
    if (cap_addr.size() !== 3 || cap_addr[2] !== 32'h108 || cap_data[2] !== 32'h99 ||
        cap_ra[1] !== 4'd2) begin
      mismatched++;
      $display("FAIL ignore_words: got n=%0d a2=%h d2=%h ra1=%0d want 3 108 99 2",
               cap_addr.size(), cap_addr[2], cap_data[2], cap_ra[1]);
    end
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_restart: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_clr_abort();
    int saw_valid;
    load_rf_basic();
    clear_cap();
    mem_ready = 1'b1;
    start_op(16'h0206, 32'h100, 2'b00);
    tick();
    tick();
    tick();  // cycle 4: word 1 offered
    mem_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mem_ready = 1'b1;
    compared++;
    if ({mem_valid, busy, done} !== 3'b000 || mem_addr !== 32'h0 || mem_data !== 32'h0 ||
        wb_addr !== 32'h0 || rf_ra !== 4'd0) begin
      mismatched++;
      $display("FAIL clr_abort: got v/b/d=%b a=%h d=%h wb=%h ra=%0d want all 0",
               {mem_valid, busy, done}, mem_addr, mem_data, wb_addr, rf_ra);
    end
    clear_cap();
    saw_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_valid || busy) saw_valid++;
      tick();
    end
    compared++;
    if (saw_valid != 0 || cap_addr.size() !== 0) begin
      mismatched++;
      $display("FAIL clr_quiet: got active_cycles=%0d words=%0d want 0 0",
               saw_valid, cap_addr.size());
    end
    start_op(16'h0206, 32'h100, 2'b00);
    wait_done(100);
    compared++;
    if (cyc !== 7 || wb_addr !== 32'h10C || cap_addr.size() !== 3 || cap_addr[0] !== 32'h100 ||
        cap_data[0] !== 32'h11 || cap_addr[2] !== 32'h108 || cap_data[2] !== 32'h99) begin
      mismatched++;
      $display("FAIL clr_rerun: got cyc=%0d wb=%h n=%0d w0=%h/%h w2=%h/%h want 7 10c 3 100/11 108/99",
               cyc, wb_addr, cap_addr.size(), cap_addr[0], cap_data[0], cap_addr[2], cap_data[2]);
    end
    tick();
  endtask

  initial begin
    clr       = 1'b1;
    start     = 1'b0;
    reg_list  = '0;
    base_addr = '0;
    mode      = '0;
    mem_ready = 1'b1;
    cyc       = 0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_ia();
    test_modes();
    test_backpressure();
    test_wrap_full();
    test_empty();
    test_start_ignored();
    test_clr_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
